// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex 7-segment scan driver, double-buffered image.
// Optional leading-zero blanking: define SEG7_LZ_BLANK_EN.
module seg7_scan_driver #(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*NUM_DIGITS-1:0] data_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   digit_en,
   input  logic                    load,
   output logic                    upd_pending,
   output logic                    frame_tick,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   an
);

   localparam int DIV_W = $clog2(REFRESH_DIV);
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
   localparam logic [DIV_W-1:0] BLANK    = DIV_W'(BLANK_CYCLES);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

   logic [DIV_W-1:0]        r_div;
   logic [IDX_W-1:0]        r_idx;
   logic [4*NUM_DIGITS-1:0] r_act_data;
   logic [NUM_DIGITS-1:0]   r_act_dp;
   logic [NUM_DIGITS-1:0]   r_act_en;
   logic [4*NUM_DIGITS-1:0] r_pnd_data;
   logic [NUM_DIGITS-1:0]   r_pnd_dp;
   logic [NUM_DIGITS-1:0]   r_pnd_en;
   logic                    r_upd_pending;
   logic                    r_started;
   logic                    r_frame_tick;
   logic [6:0]              r_seg;
   logic                    r_dp;
   logic [NUM_DIGITS-1:0]   r_an;

   logic                    w_div_last;
   logic                    w_boundary;
   logic [NUM_DIGITS-1:0]   w_en_eff;
   logic [3:0]              w_nib;
   logic                    w_dp_bit;
   logic                    w_en_bit;
   logic [NUM_DIGITS-1:0]   w_onehot;
   logic                    w_sel;
   logic [6:0]              w_seg_dec;

   assign w_div_last = (r_div == DIV_LAST);
   assign w_boundary = w_div_last && (r_idx == IDX_LAST);

   // Slot counter and digit index, wrapping once per frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_div <= '0;
         r_idx <= '0;
      end else if (w_div_last) begin
         r_div <= '0;
         r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end else begin
         r_div <= r_div + 1'b1;
      end
   end

   // Pending/active images; active only changes at the frame boundary
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_act_data    <= '0;
         r_act_dp      <= '0;
         r_act_en      <= '0;
         r_pnd_data    <= '0;
         r_pnd_dp      <= '0;
         r_pnd_en      <= '0;
         r_upd_pending <= 1'b0;
      end else if (w_boundary) begin
         if (load) begin
            r_act_data <= data_in;
            r_act_dp   <= dp_in;
            r_act_en   <= digit_en;
         end else if (r_upd_pending) begin
            r_act_data <= r_pnd_data;
            r_act_dp   <= r_pnd_dp;
            r_act_en   <= r_pnd_en;
         end
         r_upd_pending <= 1'b0;
      end else if (load) begin
         r_pnd_data    <= data_in;
         r_pnd_dp      <= dp_in;
         r_pnd_en      <= digit_en;
         r_upd_pending <= 1'b1;
      end
   end

   // Frame tick aligned with outputs showing slot 0 of a later frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_started    <= 1'b0;
         r_frame_tick <= 1'b0;
      end else begin
         r_started    <= r_started | w_boundary;
         r_frame_tick <= r_started && (r_idx == '0) && (r_div == '0);
      end
   end

`ifdef SEG7_LZ_BLANK_EN
   logic [NUM_DIGITS-1:0] w_lz_mask;
   logic                  w_lz_run;

   // Blank leading zero digits (no dp) from the top, never digit 0
   always_comb begin
      w_lz_mask = '0;
      w_lz_run  = 1'b1;
      for (int k = NUM_DIGITS - 1; k > 0; k--) begin
         if (w_lz_run && (r_act_data[4*k +: 4] == 4'h0) && !r_act_dp[k])
            w_lz_mask[k] = 1'b1;
         else
            w_lz_run = 1'b0;
      end
   end

   assign w_en_eff = r_act_en & ~w_lz_mask;
`else
   assign w_en_eff = r_act_en;
`endif

   // Select the current digit's nibble, dp, enable and anode bit
   always_comb begin
      w_nib    = 4'h0;
      w_dp_bit = 1'b0;
      w_en_bit = 1'b0;
      w_onehot = '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (r_idx == IDX_W'(k)) begin
            w_nib       = r_act_data[4*k +: 4];
            w_dp_bit    = r_act_dp[k];
            w_en_bit    = w_en_eff[k];
            w_onehot[k] = 1'b1;
         end
      end
   end

   assign w_sel = (r_div >= BLANK) && w_en_bit;

   // Hex to active-low {g,f,e,d,c,b,a}
   always_comb begin
      w_seg_dec = 7'h7F;
      case (w_nib)
         4'h0: w_seg_dec = 7'h40;
         4'h1: w_seg_dec = 7'h79;
         4'h2: w_seg_dec = 7'h24;
         4'h3: w_seg_dec = 7'h30;
         4'h4: w_seg_dec = 7'h19;
         4'h5: w_seg_dec = 7'h12;
         4'h6: w_seg_dec = 7'h02;
         4'h7: w_seg_dec = 7'h78;
         4'h8: w_seg_dec = 7'h00;
         4'h9: w_seg_dec = 7'h10;
         4'hA: w_seg_dec = 7'h08;
         4'hB: w_seg_dec = 7'h03;
         4'hC: w_seg_dec = 7'h46;
         4'hD: w_seg_dec = 7'h21;
         4'hE: w_seg_dec = 7'h06;
         4'hF: w_seg_dec = 7'h0E;
         default: w_seg_dec = 7'h7F;
      endcase
   end

   // Registered pin drivers, dark while in dead time or disabled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_an  <= '1;
         r_seg <= 7'h7F;
         r_dp  <= 1'b1;
      end else begin
         r_an  <= w_sel ? ~w_onehot : '1;
         r_seg <= w_sel ? w_seg_dec : 7'h7F;
         r_dp  <= w_sel ? ~w_dp_bit : 1'b1;
      end
   end

   assign upd_pending = r_upd_pending;
   assign frame_tick  = r_frame_tick;
   assign seg         = r_seg;
   assign dp          = r_dp;
   assign an          = r_an;

endmodule
